// File: rtl/bram_reader_pkg.sv
// Shared definitions for the BRAM burst reader: FSM encoding, output buffer depth
// and the read latency of the dp_bram port.
package bram_reader_pkg;

  localparam int FIFO_DEPTH      = 2;
  localparam int BRAM_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bram_reader_fifo2.sv
// Two-entry output buffer for the burst reader; the head entry is presented
// combinationally from storage.
module bram_reader_fifo2
  import bram_reader_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_i) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/bram_burst_reader.sv
// Streams contiguous BRAM regions out on a valid/ready master port with a last flag.
// Optional BRAM_READER_STALL_CNT_EN adds stall_cnt_o, counting backpressured cycles.
module bram_burst_reader
  import bram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  output logic                  bram_en_o,
  output logic                  bram_we_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [DATA_WIDTH-1:0] bram_din_o,
  input  logic [DATA_WIDTH-1:0] bram_dout_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
`ifdef BRAM_READER_STALL_CNT_EN
  output logic [31:0]           stall_cnt_o,
`endif
  output logic                  done_o
);

  localparam int CREDIT_W = $clog2(FIFO_DEPTH + BRAM_RD_LATENCY + 2);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  left_q;
  logic                  alive_q;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic                  accept;
  logic                  from_fifo;
  logic                  hs;
  logic                  push;
  logic                  pop;
  logic                  can_issue;
  logic                  last_issue;
  logic [CREDIT_W-1:0]   used_c;
  logic [CREDIT_W-1:0]   limit_c;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [1:0]            fifo_count;

  assign accept      = req_valid_i && req_ready_o;
  assign req_ready_o = alive_q && (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign bram_we_o   = 1'b0;
  assign bram_din_o  = '0;
  assign bram_addr_o = addr_q;

  // With an empty buffer the word arriving from the BRAM is shown directly, so
  // a burst's first word appears in the cycle its read data returns.
  assign from_fifo = (fifo_count != 2'd0);
  assign m_valid_o = from_fifo || inflight_q;
  assign m_data_o  = from_fifo ? fifo_head[DATA_WIDTH-1:0]
                               : (inflight_q ? bram_dout_i : '0);
  assign m_last_o  = from_fifo ? fifo_head[DATA_WIDTH] : (inflight_q && inflight_last_q);
  assign hs        = m_valid_o && m_ready_i;
  assign pop       = from_fifo && hs;
  assign push      = inflight_q && (from_fifo || !m_ready_i);

  // Credit: buffered + in-flight + this read must fit, a word leaving this cycle frees a slot.
  assign used_c     = CREDIT_W'(fifo_count) + CREDIT_W'(inflight_q) + CREDIT_W'(1);
  assign limit_c    = CREDIT_W'(FIFO_DEPTH) + CREDIT_W'(hs);
  assign can_issue  = (used_c <= limit_c);
  assign bram_en_o  = (state_q == ST_ISSUE) && can_issue;
  assign last_issue = bram_en_o && (left_q == LEN_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (req_len_i == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (hs && m_last_o) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      left_q          <= '0;
      alive_q         <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      alive_q         <= 1'b1;
      inflight_q      <= bram_en_o;
      inflight_last_q <= last_issue;
      if (accept) begin
        addr_q <= req_addr_i;
        left_q <= req_len_i;
      end else if (bram_en_o) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        left_q <= left_q - LEN_WIDTH'(1);
      end
    end
  end

  bram_reader_fifo2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (push),
    .push_data_i ({inflight_last_q, bram_dout_i}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

`ifdef BRAM_READER_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_cnt_o <= '0;
    end else if (accept) begin
      stall_cnt_o <= '0;
    end else if (m_valid_o && !m_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader with a behavioural 1-cycle-latency BRAM
// holding ram[i] = i.
module tb_bram_burst_reader;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = '0;
  logic [8:0]  req_len = '0;
  logic        bram_en, bram_we;
  logic [7:0]  bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout = '0;
  logic [31:0] m_data;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic        busy, done;
`ifdef BRAM_READER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  logic [31:0] ram [0:255];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Data not read this cycle is poisoned so a mistimed sample shows up as bad data.
  always @(posedge clk) begin
    if (bram_en) bram_dout <= ram[bram_addr];
    else         bram_dout <= 32'hBAD0_BAD0;
  end

  bram_burst_reader dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .bram_en_o   (bram_en),
    .bram_we_o   (bram_we),
    .bram_addr_o (bram_addr),
    .bram_din_o  (bram_din),
    .bram_dout_i (bram_dout),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_last_o    (m_last),
    .m_ready_i   (m_ready),
    .busy_o      (busy),
`ifdef BRAM_READER_STALL_CNT_EN
    .stall_cnt_o (stall_cnt),
`endif
    .done_o      (done)
  );

  task automatic check_outputs_zero(input string tag);
    tests_run++;
    if ({req_ready, busy, done, m_valid, m_last, bram_en, bram_we} !== 7'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_ctrl: got %b expected 0000000", tag,
               {req_ready, busy, done, m_valid, m_last, bram_en, bram_we});
    end
    tests_run++;
    if ({m_data, bram_din, bram_addr} !== 72'd0) begin
      tests_failed++;
      $display("[TB] FAIL %s_data: m_data=%h bram_din=%h bram_addr=%h expected all 0",
               tag, m_data, bram_din, bram_addr);
    end
  endtask

  // Presents a request and returns 1ns after the edge that accepted it.
  task automatic send_req(input logic [7:0] a, input logic [8:0] l, output logic ok);
    int g;
    req_addr = a; req_len = l; req_valid = 1'b1; g = 0; ok = 1'b0;
    @(negedge clk);
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    tests_run++;
    if (!req_ready) begin
      tests_failed++;
      $display("[TB] FAIL req_accept: req_ready=%b expected 1 within 20 cycles", req_ready);
    end else ok = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Runs one burst to completion. mode 0: ready always high; mode 1: ready 1,0,0 repeating.
  // k counts cycles after the accept edge (k=1 is the first issue cycle).
  task automatic run_stream(input logic [7:0] base, input int len, input int mode,
                            input string tag, output int first_k, output int done_k);
    int issued, got, done_cnt;
    logic stalled, held_last, hsk;
    logic [31:0] held_data, exp_data;
    logic [7:0] exp_addr;
    issued = 0; got = 0; done_cnt = 0; stalled = 1'b0;
    first_k = -1; done_k = -1; held_data = '0; held_last = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      m_ready = (mode == 0) ? 1'b1 : ((k % 3) == 1);
      @(negedge clk);
      hsk = m_valid && m_ready;
      if (m_valid && first_k < 0) first_k = k;
      if (stalled) begin
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== held_data || m_last !== held_last) begin
          tests_failed++;
          $display("[TB] FAIL %s_stable k=%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   tag, k, m_valid, m_data, m_last, held_data, held_last);
        end
      end
      if (bram_en) begin
        exp_addr = base + 8'(issued);
        tests_run++;
        if (bram_addr !== exp_addr || bram_we !== 1'b0 || bram_din !== 32'd0) begin
          tests_failed++;
          $display("[TB] FAIL %s_addr k=%0d: got addr=%h we=%b din=%h expected addr=%h we=0 din=0",
                   tag, k, bram_addr, bram_we, bram_din, exp_addr);
        end
        tests_run++;
        if (issued - got - (hsk ? 1 : 0) >= 2) begin
          tests_failed++;
          $display("[TB] FAIL %s_credit k=%0d: read issued with %0d words committed, expected at most 1",
                   tag, k, issued - got - (hsk ? 1 : 0));
        end
        issued++;
      end
      if (hsk) begin
        exp_data = {24'd0, base + 8'(got)};
        tests_run++;
        if (m_data !== exp_data || m_last !== (got == len - 1)) begin
          tests_failed++;
          $display("[TB] FAIL %s_word%0d: got d=%h l=%b expected d=%h l=%b",
                   tag, got, m_data, m_last, exp_data, (got == len - 1));
        end
        got++;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      stalled = m_valid && !m_ready;
      held_data = m_data; held_last = m_last;
      if (done_k > 0 && k >= done_k + 2) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    tests_run++;
    if (got != len || issued != len || done_cnt != 1) begin
      tests_failed++;
      $display("[TB] FAIL %s_totals: got words=%0d reads=%0d done_pulses=%0d expected %0d %0d 1",
               tag, got, issued, done_cnt, len, len);
    end
  endtask

  task automatic test_reset;
    #12;
    check_outputs_zero("reset_hold");
    @(negedge clk); rstn = 1'b1; #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_ready: got %b expected 0", req_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready_rise: got ready=%b busy=%b expected 1 0", req_ready, busy);
    end
  endtask

  task automatic test_basic;
    logic ok; int fk, dk;
    send_req(8'h10, 9'd4, ok);
    run_stream(8'h10, 4, 0, "basic", fk, dk);
    tests_run++;
    if (fk != 2 || dk != 6) begin
      tests_failed++;
      $display("[TB] FAIL basic_timing: got first_valid=%0d done=%0d expected 2 6", fk, dk);
    end
  endtask

  task automatic test_wrap;
    logic ok; int fk, dk;
    send_req(8'hFE, 9'd4, ok);
    run_stream(8'hFE, 4, 0, "wrap", fk, dk);
    tests_run++;
    if (fk != 2 || dk != 6) begin
      tests_failed++;
      $display("[TB] FAIL wrap_timing: got first_valid=%0d done=%0d expected 2 6", fk, dk);
    end
  endtask

  task automatic test_backpressure;
    logic ok; int fk, dk;
    send_req(8'h80, 9'd8, ok);
    run_stream(8'h80, 8, 1, "bp", fk, dk);
  endtask

  task automatic test_len_zero;
    logic ok;
    send_req(8'h20, 9'd0, ok);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (done !== (k == 1) || busy !== (k == 1) || bram_en !== 1'b0 || m_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL len0 k=%0d: got done=%b busy=%b en=%b valid=%b expected %b %b 0 0",
                 k, done, busy, bram_en, m_valid, (k == 1), (k == 1));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_burst;
    logic ok; int g, fk, dk;
    send_req(8'h00, 9'd16, ok);
    g = 0;
    @(negedge clk);
    while (!(m_valid && m_data == 32'd3) && g < 40) begin @(negedge clk); g++; end
    tests_run++;
    if (!(m_valid && m_data == 32'd3)) begin
      tests_failed++;
      $display("[TB] FAIL midrst_word3: got valid=%b data=%h expected 1 00000003", m_valid, m_data);
    end
    #1 rstn = 1'b0;
    #1 check_outputs_zero("midrst_async");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    send_req(8'h40, 9'd2, ok);
    run_stream(8'h40, 2, 0, "after_rst", fk, dk);
    tests_run++;
    if (fk != 2 || dk != 4) begin
      tests_failed++;
      $display("[TB] FAIL after_rst_timing: got first_valid=%0d done=%0d expected 2 4", fk, dk);
    end
  endtask

`ifdef BRAM_READER_STALL_CNT_EN
  task automatic test_stall_cnt;
    logic ok; int g, fk, dk;
    m_ready = 1'b0;
    send_req(8'h30, 9'd4, ok);
    g = 0;
    @(negedge clk);
    while (!m_valid && g < 10) begin @(negedge clk); g++; end
    repeat (5) @(posedge clk);
    #1 m_ready = 1'b1;
    g = 0;
    @(negedge clk);
    while (!done && g < 20) begin @(negedge clk); g++; end
    tests_run++;
    if (stall_cnt !== 32'd5 || done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall_cnt: got %0d done=%b expected 5 1", stall_cnt, done);
    end
    @(posedge clk); #1;
    send_req(8'h30, 9'd1, ok);
    tests_run++;
    if (stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL stall_cnt_clear: got %0d expected 0", stall_cnt);
    end
    run_stream(8'h30, 1, 0, "stall_next", fk, dk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = i;
    #2 rstn = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_reset_mid_burst();
`ifdef BRAM_READER_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000 time units, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
